// File: rtl/hd_pkg.sv
// hd_pkg: shared state encoding, op codes and defaults for the HD access blocks
package hd_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_COMMIT = 2'd2,
        S_DONE   = 2'd3
    } hd_state_e;

    localparam logic HD_OP_READ  = 1'b0;
    localparam logic HD_OP_WRITE = 1'b1;

    localparam int HD_ADDR_W  = 10;
    localparam int HD_DATA_W  = 32;
    localparam int HD_TIMEOUT = 255;

endpackage

// File: rtl/hd_timeout_counter.sv
// hd_timeout_counter: counts enabled cycles and flags the cycle whose count reaches TIMEOUT
module hd_timeout_counter
    import hd_pkg::*;
#(
    parameter int TIMEOUT = HD_TIMEOUT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT);

    logic [7:0] r_count;
    logic [7:0] w_next;

    assign w_next    = r_count + 8'd1;
    assign o_expired = i_enable && (w_next == LIMIT);

    // count enabled cycles; clear restarts from zero
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_count <= 8'd0;
        else if (i_clear)
            r_count <= 8'd0;
        else if (i_enable)
            r_count <= w_next;
    end

endmodule

// File: rtl/hd_access_ctrl.sv
// hd_access_ctrl: moves one word between HD memory and the register file on a CPU start pulse
module hd_access_ctrl
    import hd_pkg::*;
#(
    parameter int ADDR_W  = HD_ADDR_W,
    parameter int DATA_W  = HD_DATA_W,
    parameter int TIMEOUT = HD_TIMEOUT
) (
    input  logic              clock,
    input  logic              resetCPU,
    input  logic              start,
    input  logic              opWrite,
    input  logic [ADDR_W-1:0] hdAddr,
    input  logic [DATA_W-1:0] outHD,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              wrenHD,
    output logic [DATA_W-1:0] writeHD,
    output logic              memReq,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    input  logic              memAck,
    input  logic [DATA_W-1:0] memRdata
);

    hd_state_e r_state;
    logic      r_op;
    logic      w_accept;
    logic      w_expired;

    assign w_accept = (r_state == S_IDLE) && start;

    hd_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .i_clk     (clock),
        .i_rst     (resetCPU),
        .i_clear   (w_accept),
        .i_enable  (r_state == S_ACCESS),
        .o_expired (w_expired)
    );

    // control FSM with all outputs registered; ack takes priority over timeout
    always_ff @(posedge clock or posedge resetCPU) begin
        if (resetCPU) begin
            r_state  <= S_IDLE;
            r_op     <= HD_OP_READ;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            wrenHD   <= 1'b0;
            writeHD  <= '0;
            memReq   <= 1'b0;
            memWe    <= 1'b0;
            memAddr  <= '0;
            memWdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_op     <= opWrite;
                        memAddr  <= hdAddr;
                        memWdata <= outHD;
                        memWe    <= opWrite;
                        memReq   <= 1'b1;
                        error    <= 1'b0;
                        busy     <= 1'b1;
                        r_state  <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (memAck) begin
                        memReq <= 1'b0;
                        memWe  <= 1'b0;
                        if (r_op == HD_OP_READ) begin
                            writeHD <= memRdata;
                            wrenHD  <= 1'b1;
                            r_state <= S_COMMIT;
                        end else begin
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end else if (w_expired) begin
                        memReq  <= 1'b0;
                        memWe   <= 1'b0;
                        error   <= 1'b1;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_COMMIT: begin
                    wrenHD  <= 1'b0;
                    done    <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hd_access_ctrl.sv
// tb_hd_access_ctrl: directed checks of the HD access controller with TIMEOUT=4
module tb_hd_access_ctrl;

    logic        clock = 1'b0;
    logic        resetCPU = 1'b1;
    logic        start = 1'b0;
    logic        opWrite = 1'b0;
    logic [9:0]  hdAddr = '0;
    logic [31:0] outHD = '0;
    logic        busy, done, error, wrenHD, memReq, memWe;
    logic [31:0] writeHD, memWdata;
    logic [9:0]  memAddr;
    logic        memAck = 1'b0;
    logic [31:0] memRdata = '0;

    int n_checks = 0;
    int n_fail = 0;

    hd_access_ctrl #(.ADDR_W(10), .DATA_W(32), .TIMEOUT(4)) dut (
        .clock    (clock),
        .resetCPU (resetCPU),
        .start    (start),
        .opWrite  (opWrite),
        .hdAddr   (hdAddr),
        .outHD    (outHD),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .wrenHD   (wrenHD),
        .writeHD  (writeHD),
        .memReq   (memReq),
        .memWe    (memWe),
        .memAddr  (memAddr),
        .memWdata (memWdata),
        .memAck   (memAck),
        .memRdata (memRdata)
    );

    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic b, input logic d, input logic e, input logic w, input logic r);
        chk({tag, "_busy"}, {31'd0, busy}, {31'd0, b});
        chk({tag, "_done"}, {31'd0, done}, {31'd0, d});
        chk({tag, "_error"}, {31'd0, error}, {31'd0, e});
        chk({tag, "_wren"}, {31'd0, wrenHD}, {31'd0, w});
        chk({tag, "_req"}, {31'd0, memReq}, {31'd0, r});
    endtask

    initial begin
        #1;
        chk_ctl("rst", 0, 0, 0, 0, 0);
        chk("rst_addr", {22'd0, memAddr}, 32'd0);
        chk("rst_wdata", memWdata, 32'd0);
        chk("rst_wdata_hd", writeHD, 32'd0);
        cyc();
        resetCPU = 1'b0;
        cyc();

        // read, ack in third ACCESS cycle
        start = 1; opWrite = 0; hdAddr = 10'h005; outHD = 32'hAAAA_AAAA;
        cyc();
        start = 0;
        chk_ctl("rd_a1", 1, 0, 0, 0, 1);
        chk("rd_a1_addr", {22'd0, memAddr}, 32'h005);
        chk("rd_a1_we", {31'd0, memWe}, 32'd0);
        cyc();
        chk_ctl("rd_a2", 1, 0, 0, 0, 1);
        cyc();
        chk_ctl("rd_a3", 1, 0, 0, 0, 1);
        chk("rd_a3_addr", {22'd0, memAddr}, 32'h005);
        memAck = 1; memRdata = 32'hDEAD_BEEF;
        cyc();
        memAck = 0; memRdata = 32'h0;
        chk_ctl("rd_commit", 1, 0, 0, 1, 0);
        chk("rd_commit_data", writeHD, 32'hDEAD_BEEF);
        cyc();
        chk_ctl("rd_done", 1, 1, 0, 0, 0);
        chk("rd_done_data", writeHD, 32'hDEAD_BEEF);
        cyc();
        chk_ctl("rd_idle", 0, 0, 0, 0, 0);

        // write, outHD changes after start
        start = 1; opWrite = 1; hdAddr = 10'h3FF; outHD = 32'h1234_5678;
        cyc();
        start = 0; outHD = 32'h0;
        chk_ctl("wr_a1", 1, 0, 0, 0, 1);
        chk("wr_a1_we", {31'd0, memWe}, 32'd1);
        chk("wr_a1_addr", {22'd0, memAddr}, 32'h3FF);
        chk("wr_a1_wdata", memWdata, 32'h1234_5678);
        cyc();
        chk("wr_a2_wdata", memWdata, 32'h1234_5678);
        chk("wr_a2_we", {31'd0, memWe}, 32'd1);
        memAck = 1;
        cyc();
        memAck = 0;
        chk_ctl("wr_done", 1, 1, 0, 0, 0);
        cyc();
        chk_ctl("wr_idle", 0, 0, 0, 0, 0);

        // timeout, no ack
        start = 1; opWrite = 0; hdAddr = 10'h010;
        cyc();
        start = 0;
        chk_ctl("to_a1", 1, 0, 0, 0, 1);
        cyc();
        chk_ctl("to_a2", 1, 0, 0, 0, 1);
        cyc();
        chk_ctl("to_a3", 1, 0, 0, 0, 1);
        cyc();
        chk_ctl("to_a4", 1, 0, 0, 0, 1);
        cyc();
        chk_ctl("to_done", 1, 1, 1, 0, 0);
        cyc();
        chk_ctl("to_idle", 0, 0, 1, 0, 0);

        // starts ignored during ACCESS and DONE; this start clears error
        start = 1; opWrite = 0; hdAddr = 10'h020;
        cyc();
        chk_ctl("ig_a1", 1, 0, 0, 0, 1);
        chk("ig_a1_addr", {22'd0, memAddr}, 32'h020);
        hdAddr = 10'h0AB;
        cyc();
        start = 0;
        chk("ig_a2_addr", {22'd0, memAddr}, 32'h020);
        memAck = 1; memRdata = 32'h55AA_55AA;
        cyc();
        memAck = 0;
        chk_ctl("ig_commit", 1, 0, 0, 1, 0);
        chk("ig_commit_data", writeHD, 32'h55AA_55AA);
        cyc();
        chk_ctl("ig_done", 1, 1, 0, 0, 0);
        start = 1; hdAddr = 10'h0CD;
        cyc();
        start = 0;
        chk_ctl("ig_idle", 0, 0, 0, 0, 0);
        chk("ig_idle_addr", {22'd0, memAddr}, 32'h020);
        cyc();
        chk_ctl("ig_idle2", 0, 0, 0, 0, 0);

        // ack in the cycle the counter expires
        start = 1; opWrite = 0; hdAddr = 10'h111;
        cyc();
        start = 0;
        cyc();
        cyc();
        cyc();
        chk_ctl("tie_a4", 1, 0, 0, 0, 1);
        memAck = 1; memRdata = 32'hCAFE_F00D;
        cyc();
        memAck = 0;
        chk_ctl("tie_commit", 1, 0, 0, 1, 0);
        chk("tie_data", writeHD, 32'hCAFE_F00D);
        cyc();
        chk_ctl("tie_done", 1, 1, 0, 0, 0);
        cyc();

        // async reset during ACCESS, late ack ignored
        start = 1; opWrite = 1; hdAddr = 10'h222; outHD = 32'h7777_7777;
        cyc();
        start = 0;
        chk_ctl("mr_a1", 1, 0, 0, 0, 1);
        #2;
        resetCPU = 1;
        #1;
        chk_ctl("mr_rst", 0, 0, 0, 0, 0);
        chk("mr_rst_addr", {22'd0, memAddr}, 32'd0);
        chk("mr_rst_we", {31'd0, memWe}, 32'd0);
        cyc();
        resetCPU = 0; memAck = 1; memRdata = 32'hFFFF_FFFF;
        cyc();
        memAck = 0;
        chk_ctl("mr_late", 0, 0, 0, 0, 0);
        chk("mr_late_data", writeHD, 32'd0);

        // normal read after reset, ack in first ACCESS cycle
        start = 1; opWrite = 0; hdAddr = 10'h005;
        cyc();
        start = 0;
        chk_ctl("pr_a1", 1, 0, 0, 0, 1);
        memAck = 1; memRdata = 32'h0102_0304;
        cyc();
        memAck = 0;
        chk_ctl("pr_commit", 1, 0, 0, 1, 0);
        chk("pr_data", writeHD, 32'h0102_0304);
        cyc();
        chk_ctl("pr_done", 1, 1, 0, 0, 0);
        cyc();
        chk_ctl("pr_idle", 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hd_access_ctrl.md
Name: hd_access_ctrl

Overview:
- Disk-side counterpart of the register file's HD port: services CPU requests to move one word between the HD word memory and the register selected by register 17.
- Read (disk→register): fetches a word from HD memory and drives writeHD/wrenHD into the register file.
- Write (register→disk): captures outHD and stores it into HD memory.
- Sits between the CPU control unit (start/busy/done) and the HD memory (req/ack handshake with variable latency).

Parameters:
ADDR_W, 10, HD word address width
DATA_W, 32, data word width; must match the register file
TIMEOUT, 255, max cycles in ACCESS without memAck before aborting; range 1..255

Ports:
clock  in  1  system clock; all state updates on posedge
resetCPU  in  1  asynchronous, active-high reset
start  in  1  one-cycle request pulse from control unit
opWrite  in  1  0 = read disk→register, 1 = write register→disk; sampled with start
hdAddr  in  ADDR_W  HD word address; sampled with start
outHD  in  DATA_W  register-file word at index reg17[4:0]; sampled with start
busy  out  1  high from the cycle after an accepted start until done is asserted
done  out  1  one-cycle completion pulse, success or error
error  out  1  sticky timeout flag; cleared by the next accepted start
wrenHD  out  1  register-file HD write enable, one cycle per successful read
writeHD  out  DATA_W  data for the register-file HD write
memReq  out  1  HD memory request, level
memWe  out  1  1 = memory write; valid while memReq=1
memAddr  out  ADDR_W  memory address; valid while memReq=1
memWdata  out  DATA_W  memory write data; valid while memReq=1
memAck  in  1  one-cycle acknowledge from HD memory
memRdata  in  DATA_W  read data; valid in the memAck cycle

Behaviour:
- All outputs are registered.
- Reset (async, any time, including mid-operation): state=IDLE; busy, done, error, wrenHD, memReq, memWe = 0; writeHD, memAddr, memWdata, timeout counter = 0. An in-flight memory request is abandoned; a late memAck arriving in IDLE is ignored.
- States: IDLE, ACCESS, COMMIT, DONE.
- IDLE: start=1 → latch opWrite, hdAddr and outHD (into memWdata); clear error and counter; go to ACCESS.
- ACCESS:
  - memReq=1; memWe=latched op; memAddr and memWdata stay stable until exit.
  - Counter increments each cycle.
  - memAck=1 and op=read → capture memRdata into writeHD; go to COMMIT.
  - memAck=1 and op=write → go to DONE.
  - Counter reaches TIMEOUT without memAck → set error; go to DONE with no register write.
  - memAck wins over timeout in the same cycle.
  - memReq drops on exit.
- COMMIT: wrenHD=1 for exactly this cycle; writeHD holds its value through the following cycle. The register file samples on negedge, mid-cycle.
- DONE: done=1 for one cycle → IDLE.
- busy=1 in ACCESS, COMMIT and DONE; done and busy overlap in the DONE cycle.
- start while busy: ignored, with no side effects. start in the DONE cycle is also ignored. Back-to-back operations need start in IDLE.
- Latency from the start cycle N, with memAck in the first ACCESS cycle (N+1):
  - Read: wrenHD at N+2, done at N+3.
  - Write: done at N+2.
- The word written to disk is outHD as sampled in the start cycle. Later changes to reg17 do not affect it.
- The controller never drives the register-file escrita, rjal or savePC paths.

Decomposition:
- Shared package hd_pkg:
  - State enum (IDLE/ACCESS/COMMIT/DONE).
  - Op constants HD_OP_READ=0, HD_OP_WRITE=1.
  - Default HD_ADDR_W and HD_TIMEOUT.
  - Reused by the HD memory model and the control unit.
- Sub-module hd_timeout_counter:
  - Inputs: clear/enable.
  - Output: expired when count==TIMEOUT.
  - Naturally separable and reused by future HD blocks.
- The FSM and datapath registers stay in hd_access_ctrl.

Test Plan:
- Reset during ACCESS (memReq=1) → memReq, busy, error, wrenHD all 0 within the reset assertion; a later memAck ignored; next start behaves normally.
- Read: memory[0x005]=0xDEADBEEF, start opWrite=0 hdAddr=0x005, memAck 3 cycles later → memReq=1 for 3 cycles with memAddr=0x005; wrenHD=1 one cycle with writeHD=0xDEADBEEF; done next cycle; error=0.
- Write: outHD=0x12345678 at start, opWrite=1 hdAddr=0x3FF, outHD changed to 0 next cycle, memAck after 1 cycle → memWe=1, memWdata=0x12345678, memAddr=0x3FF; no wrenHD; done pulse.
- Timeout: TIMEOUT=4, memAck never asserted → memReq high exactly 4 cycles; error=1 with done; no wrenHD; the next successful start clears error.
- Ignored start: second start (different address) during ACCESS and during DONE → no change to memAddr; only one done pulse.
- Ack/timeout tie: memAck in the cycle the counter expires → treated as success; error=0 and wrenHD pulses with memRdata.
